// File: rtl/riscv_regfile_mp.sv
// -----------------------------------------------------------------------------
// riscv_regfile_mp
//
// Multi-port integer register file for the superscalar RV64 core. Each
// register carries a pending (scoreboard) bit. Issue logic allocates a
// destination, which sets its bit. Writeback to that register clears it.
// x0 is hardwired to zero and is never pending.
//
// Optional feature macro: RISCV_REGFILE_BYPASS_EN
//   defined   : read ports forward same-cycle write data and the cleared busy
//               state.
//   undefined : read ports return stored state only, so a write is visible on
//               reads one cycle later.
//
// Parameters
//   XLEN   register width
//   NREGS  architectural register count (power of two, >= 2)
//   NRD    number of combinational read ports
//   NWR    number of synchronous write ports
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset; clears data, pending and count
//   rd_addr     NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data     NRD packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy     pending bit of each addressed register
//   wr_en       per-port write enable
//   wr_addr     NWR packed write addresses
//   wr_data     NWR packed write data
//   alloc_en    mark alloc_addr pending at the next edge
//   alloc_addr  register to mark (0 is ignored)
//   flush       clear every pending bit; data writes still happen
//   pend_cnt    registered population count of the pending vector
// -----------------------------------------------------------------------------
module riscv_regfile_mp #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = $clog2(NREGS),
   localparam int CW   = $clog2(NREGS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic                 alloc_en,
   input  logic [AW-1:0]        alloc_addr,
   input  logic                 flush,
   output logic [CW-1:0]        pend_cnt
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  regs_reg [NREGS];
   logic [NREGS-1:0] pending_reg;
   logic [NREGS-1:0] pending_next;
   logic [CW-1:0]    pend_cnt_reg;
   logic [CW-1:0]    pend_cnt_next;

   // ------------------------------------------------------------------------
   // Write port unpacking. A port is "active" only when it is enabled and
   // targets a non-zero register, so x0 can never be written or forwarded.
   // ------------------------------------------------------------------------
   logic [AW-1:0]   wr_addr_a [NWR];
   logic [XLEN-1:0] wr_data_a [NWR];
   logic [NWR-1:0]  wr_act;

   generate
      for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_unpack
         assign wr_addr_a[gi] = wr_addr[gi*AW +: AW];
         assign wr_data_a[gi] = wr_data[gi*XLEN +: XLEN];
         assign wr_act[gi]    = wr_en[gi] && (wr_addr_a[gi] != '0);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Per-register write decode and storage. Ports are scanned in ascending
   // order so the highest-index matching port is the one that sticks.
   // ------------------------------------------------------------------------
   logic [NREGS-1:0] wr_hit;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
         logic            hit;
         logic [XLEN-1:0] sel;

         always_comb begin
            hit = 1'b0;
            sel = '0;
            for (int p = 0; p < NWR; p++) begin
               if (wr_act[p] && (wr_addr_a[p] == AW'(gi))) begin
                  hit = 1'b1;
                  sel = wr_data_a[p];
               end
            end
         end

         assign wr_hit[gi] = hit;

         // Entry 0 never sees a hit (active ports exclude address 0), so it
         // holds its reset value of zero forever.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               regs_reg[gi] <= '0;
            end else if (hit) begin
               regs_reg[gi] <= sel;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Pending vector. Precedence: flush > allocation > write clear > hold.
   // Allocation is applied after the write clear so a new producer issued in
   // the same cycle as the old producer's writeback keeps the register busy.
   // ------------------------------------------------------------------------
   always_comb begin
      pending_next = pending_reg;
      if (flush) begin
         pending_next = '0;
      end else begin
         pending_next = pending_reg & ~wr_hit;
         if (alloc_en && (alloc_addr != '0)) begin
            pending_next[alloc_addr] = 1'b1;
         end
      end
      pending_next[0] = 1'b0;
   end

   // The count is computed from the next vector, so the register always
   // equals the population count of pending_reg.
   always_comb begin
      pend_cnt_next = '0;
      for (int r = 0; r < NREGS; r++) begin
         pend_cnt_next = pend_cnt_next + CW'(pending_next[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg  <= '0;
         pend_cnt_reg <= '0;
      end else begin
         pending_reg  <= pending_next;
         pend_cnt_reg <= pend_cnt_next;
      end
   end

   assign pend_cnt = pend_cnt_reg;

   // ------------------------------------------------------------------------
   // Read ports (combinational)
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] stored_data;
         logic            stored_busy;
         logic [XLEN-1:0] data_out;
         logic            busy_out;

         assign ra          = rd_addr[gi*AW +: AW];
         assign stored_data = (ra == '0) ? '0 : regs_reg[ra];
         assign stored_busy = pending_reg[ra];

`ifdef RISCV_REGFILE_BYPASS_EN
         logic fwd;

         always_comb begin
            data_out = stored_data;
            fwd      = 1'b0;
            for (int p = 0; p < NWR; p++) begin
               if (wr_act[p] && (wr_addr_a[p] == ra)) begin
                  data_out = wr_data_a[p];
                  fwd      = 1'b1;
               end
            end

            // Mirror the pending precedence: flush clears, a same-cycle
            // allocation of this register keeps the stored state, otherwise
            // a matching write shows the bit as already cleared.
            busy_out = stored_busy;
            if (flush) begin
               busy_out = 1'b0;
            end else if (fwd && !(alloc_en && (alloc_addr == ra))) begin
               busy_out = 1'b0;
            end

            // Stored state is already zero during reset. Forwarded write data
            // must be suppressed too, so reads return zero while rst_n is low.
            if (!rst_n) begin
               data_out = '0;
               busy_out = 1'b0;
            end
         end
`else
         assign data_out = stored_data;
         assign busy_out = stored_busy;
`endif

         assign rd_data[gi*XLEN +: XLEN] = data_out;
         assign rd_busy[gi]              = busy_out;
      end
   endgenerate

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_riscv_regfile_mp
//
// Directed bench for riscv_regfile_mp (default parameters). The driver sets
// inputs just after each rising edge and queues the expected outputs for
// that cycle. A monitor samples on the falling edge, pops the entries for
// the current cycle and compares them. Expectations that depend on
// RISCV_REGFILE_BYPASS_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_riscv_regfile_mp;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;
   localparam int CW    = 6;

`ifdef RISCV_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                alloc_en;
   logic [AW-1:0]       alloc_addr;
   logic                flush;
   logic [CW-1:0]       pend_cnt;

   riscv_regfile_mp #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .NRD  (NRD),
      .NWR  (NWR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .alloc_en  (alloc_en),
      .alloc_addr(alloc_addr),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // kind: 0 = rd_data[port], 1 = rd_busy[port], 2 = pend_cnt
   typedef struct {
      int          cyc;
      int          kind;
      int          port;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cycle_cnt = 0;
   int   n_cmp     = 0;
   int   n_mis     = 0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // ------------------------------------------------------------------------
   // Driver helpers
   // ------------------------------------------------------------------------
   task automatic idle();
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;
      flush      = 1'b0;
      rd_addr    = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int p, input int a, input logic [63:0] d);
      wr_en[p]                = 1'b1;
      wr_addr[p*AW +: AW]     = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic alloc(input int a);
      alloc_en   = 1'b1;
      alloc_addr = AW'(a);
   endtask

   task automatic push(input int kind, input int port, input logic [63:0] v, input string n);
      exp_t e;
      e.cyc  = cycle_cnt;
      e.kind = kind;
      e.port = port;
      e.exp  = v;
      e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic exp_data(input int p, input logic [63:0] v, input string n);
      push(0, p, v, n);
   endtask

   task automatic exp_busy(input int p, input logic [63:0] v, input string n);
      push(1, p, v, n);
   endtask

   task automatic exp_cnt(input logic [63:0] v, input string n);
      push(2, 0, v, n);
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   initial begin
      exp_t        e;
      logic [63:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
            e = sb_q.pop_front();
            case (e.kind)
               0:       act = rd_data[e.port*XLEN +: XLEN];
               1:       act = {63'd0, rd_busy[e.port]};
               default: act = {{(64-CW){1'b0}}, pend_cnt};
            endcase
            n_cmp++;
            if (e.cyc != cycle_cnt || act !== e.exp) begin
               n_mis++;
               $display("FAIL %s (cycle %0d, sampled %0d): got %h, expected %h",
                        e.name, e.cyc, cycle_cnt, act, e.exp);
            end else begin
               $display("ok   %s (cycle %0d): %h", e.name, e.cyc, act);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      idle();

      // Reset held with random activity on every input.
      for (int k = 0; k < 2; k++) begin
         step();
         wr_en      = 2'b11;
         wr_addr    = NWR*AW'($urandom);
         wr_data    = {$urandom, $urandom, $urandom, $urandom};
         alloc_en   = 1'b1;
         alloc_addr = AW'($urandom);
         rd_addr    = wr_addr;
         exp_data(0, 64'd0, "rst_data0");
         exp_data(1, 64'd0, "rst_data1");
         exp_busy(0, 64'd0, "rst_busy0");
         exp_busy(1, 64'd0, "rst_busy1");
         exp_cnt(64'd0, "rst_cnt");
      end

      // Release and sweep x1..x31.
      step();
      rst_n = 1'b1;
      for (int r = 1; r < NREGS; r++) begin
         if (r > 1) step();
         rd(0, r);
         rd(1, NREGS - r);
         exp_data(0, 64'd0, $sformatf("init_x%0d", r));
         exp_data(1, 64'd0, $sformatf("init_x%0d", NREGS - r));
         exp_busy(0, 64'd0, $sformatf("init_busy_x%0d", r));
      end

      // x0 protection.
      step();
      wr(0, 0, 64'hDEAD_BEEF_0000_0001);
      alloc(0);
      step();
      rd(0, 0); rd(1, 0);
      exp_data(0, 64'd0, "x0_data");
      exp_busy(0, 64'd0, "x0_busy");
      exp_cnt(64'd0, "x0_cnt");

      // Write collision: highest port wins.
      step();
      wr(0, 5, 64'h1111);
      wr(1, 5, 64'h2222);
      step();
      rd(0, 5); rd(1, 5);
      exp_data(0, 64'h2222, "collide_p0");
      exp_data(1, 64'h2222, "collide_p1");

      // Scoreboard: alloc, alloc+write, write.
      step();
      alloc(7);
      step();
      rd(0, 7);
      exp_busy(0, 64'd1, "alloc7_busy");
      exp_cnt(64'd1, "alloc7_cnt");
      exp_data(0, 64'd0, "alloc7_data");
      step();
      alloc(7);
      wr(1, 7, 64'h77);
      step();
      rd(0, 7);
      exp_busy(0, 64'd1, "allocwr7_busy");
      exp_cnt(64'd1, "allocwr7_cnt");
      exp_data(0, 64'h77, "allocwr7_data");
      step();
      wr(0, 7, 64'h78);
      step();
      rd(0, 7);
      exp_busy(0, 64'd0, "wr7_busy");
      exp_cnt(64'd0, "wr7_cnt");
      exp_data(0, 64'h78, "wr7_data");

      // Flush: preload data, allocate x1..x4, flush with alloc x9.
      step();
      wr(0, 1, 64'h11);
      wr(1, 4, 64'h44);
      for (int k = 1; k <= 4; k++) begin
         step();
         alloc(k);
         exp_cnt(64'(k - 1), $sformatf("ramp_cnt%0d", k - 1));
      end
      step();
      rd(0, 1); rd(1, 4);
      exp_cnt(64'd4, "pend4_cnt");
      exp_busy(0, 64'd1, "pend_x1_busy");
      exp_busy(1, 64'd1, "pend_x4_busy");
      exp_data(0, 64'h11, "pend_x1_data");
      exp_data(1, 64'h44, "pend_x4_data");
      step();
      flush = 1'b1;
      alloc(9);
      wr(0, 3, 64'h33);
      exp_cnt(64'd4, "preflush_cnt");
      step();
      rd(0, 1); rd(1, 9);
      exp_cnt(64'd0, "flush_cnt");
      exp_busy(0, 64'd0, "flush_x1_busy");
      exp_busy(1, 64'd0, "flush_x9_busy");
      exp_data(0, 64'h11, "flush_x1_data");
      exp_data(1, 64'd0, "flush_x9_data");
      step();
      rd(0, 4); rd(1, 3);
      exp_busy(0, 64'd0, "flush_x4_busy");
      exp_busy(1, 64'd0, "flush_x3_busy");
      exp_data(0, 64'h44, "flush_x4_data");
      exp_data(1, 64'h33, "flush_x3_data");

      // Same-cycle write/read of x3.
      step();
      wr(0, 3, 64'hABCD);
      rd(0, 3); rd(1, 3);
      exp_data(0, BYP ? 64'hABCD : 64'h33, "byp_x3_p0");
      exp_data(1, BYP ? 64'hABCD : 64'h33, "byp_x3_p1");
      step();
      rd(0, 3); rd(1, 3);
      exp_data(0, 64'hABCD, "after_x3_p0");
      exp_data(1, 64'hABCD, "after_x3_p1");

      // Same-cycle writeback of a pending register.
      step();
      alloc(12);
      step();
      wr(1, 12, 64'h12);
      rd(0, 12);
      exp_busy(0, BYP ? 64'd0 : 64'd1, "byp_x12_busy");
      exp_data(0, BYP ? 64'h12 : 64'd0, "byp_x12_data");
      exp_cnt(64'd1, "byp_x12_cnt");
      step();
      rd(0, 12);
      exp_busy(0, 64'd0, "after_x12_busy");
      exp_data(0, 64'h12, "after_x12_data");
      exp_cnt(64'd0, "after_x12_cnt");

      // Reset in mid-operation discards everything.
      step();
      alloc(20);
      wr(0, 20, 64'h99);
      rst_n = 1'b0;
      rd(0, 3); rd(1, 20);
      exp_data(0, 64'd0, "midrst_x3_data");
      exp_data(1, 64'd0, "midrst_x20_data");
      exp_cnt(64'd0, "midrst_cnt");
      step();
      rst_n = 1'b1;
      rd(0, 20); rd(1, 12);
      exp_data(0, 64'd0, "postrst_x20_data");
      exp_busy(0, 64'd0, "postrst_x20_busy");
      exp_data(1, 64'd0, "postrst_x12_data");
      exp_cnt(64'd0, "postrst_cnt");

      repeat (3) step();
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/riscv_regfile_mp.md
# riscv_regfile_mp

Parametrised multi-port integer register file with a per-register pending (scoreboard) bit, for the superscalar RV64 core. It provides NRD combinational read ports and NWR synchronous write ports, with x0 hardwired to zero. Issue logic uses it to mark destinations as pending, and writeback clears them. It sits between decode/issue (reads, allocation) and the writeback stage.

## Interface
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers, power of two ≥ 2; AW = $clog2(NREGS)
- NRD, 2, read ports, ≥ 1
- NWR, 2, write ports, ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  pending bit of the addressed register
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr pending (destination issued)
- alloc_addr  in  AW  register to mark
- flush  in  1  clear all pending bits (pipeline flush); data is unaffected
- pend_cnt  out  $clog2(NREGS+1)  number of registers currently pending

## Operation
- Storage:
  - NREGS × XLEN data array plus an NREGS-bit pending vector.
  - Entry 0 is never written and never pending.
  - A read of address 0 returns 0 with busy = 0.
- Write:
  - Each port with wr_en=1 and wr_addr≠0 writes wr_data at the clock edge.
  - Same address on several enabled ports in one cycle: the highest port index wins.
- Pending update, per register r≠0, at each edge:
  - If flush=1, pending[r] ← 0.
  - Else if alloc_en=1 and alloc_addr=r, pending[r] ← 1. Allocation beats a same-cycle write to r, because the new producer supersedes the old one.
  - Else if any enabled write port targets r, pending[r] ← 0.
  - Otherwise pending[r] holds.
- alloc_addr=0 is ignored.
- Write ports still update data during flush.
- pend_cnt:
  - Registered population count of the pending vector, updated in the same edge as the vector.
  - Always equals popcount(pending).
  - Range is 0..NREGS-1.
- Reads are combinational from the array and pending vector (bypass rules are under Configuration).

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - All data entries 0, all pending 0, pend_cnt = 0.
  - rd_data = 0 and rd_busy = 0 for every port.
- Reset mid-operation discards all in-flight writes and allocations immediately.
- Read latency is 0 cycles (combinational).
- Without bypass, a write is visible on reads in cycle N+1.
- Allocation is visible on rd_busy in cycle N+1.
- No handshake: every write and allocation is accepted in the cycle it is presented.

## Configuration
- Macro: RISCV_REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data. If any enabled write port with address ≠ 0 matches rd_addr, rd_data is the highest-index matching port's wr_data.
  - rd_busy reports 0 when a same-cycle matching write would clear the bit, i.e. no same-cycle alloc or flush precedence applies. With flush, rd_busy = 0.
- Undefined:
  - rd_data is the stored value only.
  - rd_busy is the stored pending bit only.
  - Write-to-read latency is one cycle.

## Test plan
- Reset: hold rst_n=0 with random inputs → every rd_data = 0, rd_busy = 0, pend_cnt = 0. Release, then read x1..x31 → all 0.
- x0 protection: write port 0, addr 0, data 64'hDEAD_BEEF_0000_0001, plus alloc x0 → read x0 returns 0, busy 0, pend_cnt 0.
- Write collision: ports 0 and 1 both write x5, with data 64'h1111 on port 0 and 64'h2222 on port 1 → next cycle x5 = 64'h2222.
- Scoreboard:
  - alloc x7 → rd_busy = 1 next cycle, pend_cnt = 1.
  - Then alloc x7 and write x7 in the same cycle → x7 stays busy, pend_cnt = 1.
  - Then write x7 alone → busy 0, pend_cnt = 0.
- Flush: alloc x1..x4 over 4 cycles → pend_cnt = 4. Then flush together with alloc x9 → all busy 0, pend_cnt = 0, data unchanged.
- Bypass: write x3 = 64'hABCD while reading x3 on both ports in the same cycle:
  - With RISCV_REGFILE_BYPASS_EN: rd_data = 64'hABCD that cycle.
  - Without it: the old value that cycle, then 64'hABCD the next.
